lcd_ctrl_param: RTL and testbench
=================================

Name: lcd_ctrl_param

Overview:
Parametrised successor of the fixed 8x8 LCD image controller. The block loads a W x H frame from IROM into an internal pixel buffer and applies cursor-window commands on a 2x2 window. It then streams the frame to IRB and can reload for further frames without reset. It sits between the host command interface and the IROM/IRB memories. New over the previous generation: arbitrary power-of-two frame size and pixel width, MAX/MIN/rotate operations, and multi-frame operation via RELOAD.

Parameters:
IMG_W_LG2, 3, log2 of frame width W (W >= 4)
IMG_H_LG2, 3, log2 of frame height H (H >= 4)
DW, 8, pixel width in bits
AW (localparam), IMG_W_LG2+IMG_H_LG2, buffer address width; N = 2^AW pixels

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
cmd  in  4  command code
cmd_valid  in  1  command strobe
IROM_Q  in  DW  IROM read data, valid one cycle after address
IROM_EN  out  1  IROM enable, active-low
IROM_A  out  AW  IROM address
IRB_RW  out  1  IRB 1=read/idle, 0=write
IRB_A  out  AW  IRB address
IRB_D  out  DW  IRB write data
busy  out  1  1 = commands ignored
done  out  1  one-cycle pulse after frame writeback completes

Behaviour:
- All outputs registered. Reset values: busy=1, done=0, IROM_EN=1, IROM_A=0, IRB_RW=1, IRB_A=0, IRB_D=0, state=LOAD, counter=0, op=(W/2, H/2).
- Pixel address = {y, x}. The window at op (opX, opY) is TL=(opX-1, opY-1), TR=(opX, opY-1), BL=(opX-1, opY), BR=(opX, opY).
- opX range is 1..W-1 and opY range is 1..H-1. Moves saturate at these limits; no wrap.
- States are LOAD, IDLE, WRITE, DONE.
- LOAD: counter c runs 0..N.
  - For c<N: IROM_EN=0, IROM_A=c.
  - For c>=1: img[c-1] <= IROM_Q.
  - LOAD lasts N+1 cycles, then goes to IDLE with busy=0 and IROM_EN=1.
- IDLE: a command is accepted on a posedge where cmd_valid=1 and busy=0. Commands presented while busy=1 are dropped, not queued.
  - Window and move commands take effect at the accept edge. The block stays in IDLE, so back-to-back commands are allowed every cycle.
- Command codes:
  - 0 WRTBK: go to WRITE; busy=1 from the next cycle.
  - 1 UP (opY-1), 2 DN (opY+1), 3 LF (opX-1), 4 RT (opX+1).
  - 5 AVG: all four window pixels <= floor((TL+TR+BL+BR)/4). Use a DW+2-bit sum with no overflow.
  - 6 MRR_X: TL<->BL, TR<->BR.
  - 7 MRR_Y: TL<->TR, BL<->BR.
  - 8 MAX: all four <= max of the four. 9 MIN: all four <= min of the four.
  - 10 ROT_CW: TL<=BL, TR<=TL, BR<=TR, BL<=BR.
  - 11 ROT_CCW: TL<=TR, TR<=BR, BR<=BL, BL<=TL.
  - 12 RELOAD: op returns to (W/2, H/2), counter=0, go to LOAD, busy=1.
  - 13-15: NOP, accepted, no effect.
- WRITE: N cycles, i=0..N-1, with IRB_RW=0, IRB_A=i, IRB_D=img[i]. The next cycle is DONE with IRB_RW=1, done=1, busy=1. DONE returns to IDLE with done=0, busy=0. Buffer and op are retained.
- Reset low in any state, mid-LOAD or mid-WRITE included: all outputs take reset values on that edge and LOAD restarts from address 0 after reset releases. Buffer contents are not cleared; the load overwrites them.

Decomposition:
- Package lcd_ctrl_pkg holds the 4-bit command codes (WRTBK..RELOAD) and the state encoding.
- Sub-module lcd_win_alu: combinational, parametrised by DW. Inputs are the four pixels and cmd; outputs are four new pixels plus a write-enable. Implements AVG/MRR/MAX/MIN/ROT.
- The top level owns the FSM, counter, op register and buffer.

Test Plan:
- Defaults, IROM[i]=i: release reset -> IROM_A steps 0..63 with IROM_EN=0, busy falls after 65 cycles. Then WRTBK -> 64 writes with IRB_A=i, IRB_D=i, then done=1 for exactly one cycle.
- AVG at op (4,4) -> pixels 27,28,35,36 all become 31 (126/4). Writeback confirms 31 at those addresses; all others unchanged.
- UP x5 and LF x5 -> op saturates at (1,1). MRR_X -> addresses 0,1,8,9 hold 8,9,0,1. DN x9 and RT x9 -> op saturates at (7,7).
- ROT_CW at (4,4) -> addresses 27,28,35,36 hold 35,27,36,28. ROT_CCW then restores 27,28,35,36. MAX at (4,4) -> all four hold 36.
- cmd_valid=1 with AVG during LOAD -> no effect. reset=0 at WRITE i=20 -> IRB_RW=1, busy=1 next edge. After release, reload from IROM_A=0 and a correct writeback.
- IMG_W_LG2=4, IMG_H_LG2=2 (16x4): op resets to (8,2). DN x3 saturates at opY=3, RT x10 at opX=15. RELOAD after done -> second 64-pixel load and a correct second writeback.

Source files
------------

// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes, FSM state encoding and command classification
// for the parametrised LCD image controller.
package lcd_ctrl_pkg;

  typedef enum logic [3:0] {
    WRTBK   = 4'd0,
    UP      = 4'd1,
    DN      = 4'd2,
    LF      = 4'd3,
    RT      = 4'd4,
    AVG     = 4'd5,
    MRR_X   = 4'd6,
    MRR_Y   = 4'd7,
    MAX     = 4'd8,
    MIN     = 4'd9,
    ROT_CW  = 4'd10,
    ROT_CCW = 4'd11,
    RELOAD  = 4'd12
  } cmd_e;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    IDLE  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Commands that rewrite the 2x2 window contents.
  function automatic logic is_win_op(input logic [3:0] c);
    return (c >= 4'(AVG)) && (c <= 4'(ROT_CCW));
  endfunction

endpackage

// File: rtl/lcd_ctrl_param_if.sv
// Host command port plus IROM/IRB memory ports of the LCD controller.
// The slave side is the controller; the master side is host plus memories.
interface lcd_ctrl_param_if #(
  parameter int AW = 6,
  parameter int DW = 8
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_EN;
  logic [AW-1:0] IROM_A;
  logic          IRB_RW;
  logic [AW-1:0] IRB_A;
  logic [DW-1:0] IRB_D;
  logic          busy;
  logic          done;

  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output IROM_EN, IROM_A, IRB_RW, IRB_A, IRB_D, busy, done
  );

  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  IROM_EN, IROM_A, IRB_RW, IRB_A, IRB_D, busy, done
  );
endinterface

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: produces the four new pixel values and
// a write enable for AVG, mirror, MAX/MIN and rotate commands.
module lcd_win_alu #(
  parameter int DW = 8
) (
  input  logic [3:0]    cmd,
  input  logic [DW-1:0] tl,
  input  logic [DW-1:0] tr,
  input  logic [DW-1:0] bl,
  input  logic [DW-1:0] br,
  output logic [DW-1:0] n_tl,
  output logic [DW-1:0] n_tr,
  output logic [DW-1:0] n_bl,
  output logic [DW-1:0] n_br,
  output logic          we
);
  import lcd_ctrl_pkg::*;

  logic [DW+1:0] sum;
  logic [DW-1:0] avg;
  logic [DW-1:0] mx_t, mx_b, mx;
  logic [DW-1:0] mn_t, mn_b, mn;

  always_comb begin
    sum  = {2'b00, tl} + {2'b00, tr} + {2'b00, bl} + {2'b00, br};
    avg  = sum[DW+1:2];
    mx_t = (tl > tr) ? tl : tr;
    mx_b = (bl > br) ? bl : br;
    mx   = (mx_t > mx_b) ? mx_t : mx_b;
    mn_t = (tl < tr) ? tl : tr;
    mn_b = (bl < br) ? bl : br;
    mn   = (mn_t < mn_b) ? mn_t : mn_b;

    n_tl = tl;
    n_tr = tr;
    n_bl = bl;
    n_br = br;
    we   = is_win_op(cmd);

    case (cmd)
      AVG: begin
        n_tl = avg; n_tr = avg; n_bl = avg; n_br = avg;
      end
      MRR_X: begin
        n_tl = bl; n_bl = tl; n_tr = br; n_br = tr;
      end
      MRR_Y: begin
        n_tl = tr; n_tr = tl; n_bl = br; n_br = bl;
      end
      MAX: begin
        n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx;
      end
      MIN: begin
        n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn;
      end
      ROT_CW: begin
        n_tl = bl; n_tr = tl; n_br = tr; n_bl = br;
      end
      ROT_CCW: begin
        n_tl = tr; n_tr = br; n_br = bl; n_bl = tl;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads a W x H frame from IROM, applies
// 2x2 window commands from the host and streams the frame back out to IRB.
module lcd_ctrl_param #(
  parameter int IMG_W_LG2 = 3,
  parameter int IMG_H_LG2 = 3,
  parameter int DW        = 8
) (
  input logic           clk,
  input logic           reset,
  lcd_ctrl_param_if.slave bus
);
  import lcd_ctrl_pkg::*;

  localparam int AW = IMG_W_LG2 + IMG_H_LG2;
  localparam int N  = 1 << AW;

  localparam logic [AW:0]          CNT_N   = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]          CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]        A_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [IMG_W_LG2-1:0] X_ONE   = {{(IMG_W_LG2-1){1'b0}}, 1'b1};
  localparam logic [IMG_W_LG2-1:0] X_MID   = {1'b1, {(IMG_W_LG2-1){1'b0}}};
  localparam logic [IMG_H_LG2-1:0] Y_ONE   = {{(IMG_H_LG2-1){1'b0}}, 1'b1};
  localparam logic [IMG_H_LG2-1:0] Y_MID   = {1'b1, {(IMG_H_LG2-1){1'b0}}};

  state_e               state, state_n;
  logic [AW:0]          cnt, cnt_n;
  logic [IMG_W_LG2-1:0] op_x, op_x_n, x_lo;
  logic [IMG_H_LG2-1:0] op_y, op_y_n, y_lo;

  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic          irom_en_q, irom_en_n;
  logic [AW-1:0] irom_a_q, irom_a_n;
  logic          irb_rw_q, irb_rw_n;
  logic [AW-1:0] irb_a_q, irb_a_n;
  logic [DW-1:0] irb_d_q, irb_d_n;

  logic [DW-1:0] img [N];
  logic          ld_we, win_we, accept;
  logic [AW-1:0] ld_addr, tl_a, tr_a, bl_a, br_a;
  logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
  logic          alu_we;

  assign x_lo   = op_x - X_ONE;
  assign y_lo   = op_y - Y_ONE;
  assign tl_a   = {y_lo, x_lo};
  assign tr_a   = {y_lo, op_x};
  assign bl_a   = {op_y, x_lo};
  assign br_a   = {op_y, op_x};
  assign accept = bus.cmd_valid & ~busy_q;

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.IROM_EN = irom_en_q;
  assign bus.IROM_A  = irom_a_q;
  assign bus.IRB_RW  = irb_rw_q;
  assign bus.IRB_A   = irb_a_q;
  assign bus.IRB_D   = irb_d_q;

  lcd_win_alu #(.DW(DW)) u_alu (
    .cmd  (bus.cmd),
    .tl   (img[tl_a]),
    .tr   (img[tr_a]),
    .bl   (img[bl_a]),
    .br   (img[br_a]),
    .n_tl (n_tl),
    .n_tr (n_tr),
    .n_bl (n_bl),
    .n_br (n_br),
    .we   (alu_we)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    op_x_n    = op_x;
    op_y_n    = op_y;
    busy_n    = busy_q;
    done_n    = 1'b0;
    irom_en_n = 1'b1;
    irom_a_n  = irom_a_q;
    irb_rw_n  = 1'b1;
    irb_a_n   = irb_a_q;
    irb_d_n   = irb_d_q;
    ld_we     = 1'b0;
    ld_addr   = cnt[AW-1:0] - A_ONE;
    win_we    = 1'b0;

    unique case (state)
      // Address c goes out with this edge; the data for c-1 is captured now.
      LOAD: begin
        busy_n = 1'b1;
        if (cnt < CNT_N) begin
          irom_en_n = 1'b0;
          irom_a_n  = cnt[AW-1:0];
        end
        if (cnt != '0) ld_we = 1'b1;
        if (cnt == CNT_N) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      IDLE: begin
        if (accept) begin
          case (bus.cmd)
            // Pixel 0 is issued on the accept edge so WRITE spans exactly N cycles.
            WRTBK: begin
              state_n  = WRITE;
              busy_n   = 1'b1;
              cnt_n    = CNT_ONE;
              irb_rw_n = 1'b0;
              irb_a_n  = '0;
              irb_d_n  = img[0];
            end
            UP:      if (op_y != Y_ONE) op_y_n = op_y - Y_ONE;
            DN:      if (op_y != '1)    op_y_n = op_y + Y_ONE;
            LF:      if (op_x != X_ONE) op_x_n = op_x - X_ONE;
            RT:      if (op_x != '1)    op_x_n = op_x + X_ONE;
            RELOAD: begin
              state_n = LOAD;
              busy_n  = 1'b1;
              cnt_n   = '0;
              op_x_n  = X_MID;
              op_y_n  = Y_MID;
            end
            default: win_we = alu_we;
          endcase
        end
      end
      WRITE: begin
        if (cnt < CNT_N) begin
          irb_rw_n = 1'b0;
          irb_a_n  = cnt[AW-1:0];
          irb_d_n  = img[cnt[AW-1:0]];
          cnt_n    = cnt + CNT_ONE;
        end else begin
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      cnt       <= '0;
      op_x      <= X_MID;
      op_y      <= Y_MID;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      irom_en_q <= 1'b1;
      irom_a_q  <= '0;
      irb_rw_q  <= 1'b1;
      irb_a_q   <= '0;
      irb_d_q   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_x      <= op_x_n;
      op_y      <= op_y_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      irom_en_q <= irom_en_n;
      irom_a_q  <= irom_a_n;
      irb_rw_q  <= irb_rw_n;
      irb_a_q   <= irb_a_n;
      irb_d_q   <= irb_d_n;
    end
  end

  // Pixel buffer keeps its contents through reset; the next load overwrites it.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (ld_we) img[ld_addr] <= bus.IROM_Q;
      if (win_we) begin
        img[tl_a] <= n_tl;
        img[tr_a] <= n_tr;
        img[bl_a] <= n_bl;
        img[br_a] <= n_br;
      end
    end
  end
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Bench for lcd_ctrl_param: an 8x8 and a 16x4 instance, directed commands,
// writeback streams compared against hand-computed frames via a scoreboard.
module tb_lcd_ctrl_param;
  import lcd_ctrl_pkg::*;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic clk  = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 clk = ~clk;

  lcd_ctrl_param_if #(.AW(6), .DW(8)) if0 ();
  lcd_ctrl_param_if #(.AW(6), .DW(8)) if1 ();

  lcd_ctrl_param #(.IMG_W_LG2(3), .IMG_H_LG2(3), .DW(8)) dut0 (
    .clk(clk), .reset(rst0), .bus(if0)
  );
  lcd_ctrl_param #(.IMG_W_LG2(4), .IMG_H_LG2(2), .DW(8)) dut1 (
    .clk(clk), .reset(rst1), .bus(if1)
  );

  logic [7:0] rom0 [64];
  logic [7:0] rom1 [64];
  assign if0.IROM_Q = if0.IROM_EN ? 8'hEE : rom0[if0.IROM_A];
  assign if1.IROM_Q = if1.IROM_EN ? 8'hEE : rom1[if1.IROM_A];

  wr_t q0[$];
  wr_t q1[$];
  int  pend0, pend1;
  int  tests, fails;
  int  m0 [64];
  int  m1 [64];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: every IRB write and every done pulse is consumed here.
  always @(negedge clk) begin
    wr_t e;
    if (if0.IRB_RW == 1'b0) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr0_extra: IRB_A=%0d IRB_D=%0d, required no write", if0.IRB_A, if0.IRB_D);
      end else begin
        e = q0.pop_front();
        chk("wr0_addr", int'(if0.IRB_A), e.a);
        chk("wr0_data", int'(if0.IRB_D), e.d);
      end
    end
    if (if0.done) begin
      tests++;
      if (pend0 == 0) begin
        fails++;
        $display("FAIL done0_extra: done=1, required 0");
      end else pend0--;
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (if1.IRB_RW == 1'b0) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL wr1_extra: IRB_A=%0d IRB_D=%0d, required no write", if1.IRB_A, if1.IRB_D);
      end else begin
        e = q1.pop_front();
        chk("wr1_addr", int'(if1.IRB_A), e.a);
        chk("wr1_data", int'(if1.IRB_D), e.d);
      end
    end
    if (if1.done) begin
      tests++;
      if (pend1 == 0) begin
        fails++;
        $display("FAIL done1_extra: done=1, required 0");
      end else pend1--;
    end
  end

  function automatic int busy_of(input int d);
    return (d == 0) ? int'(if0.busy) : int'(if1.busy);
  endfunction

  function automatic int done_of(input int d);
    return (d == 0) ? int'(if0.done) : int'(if1.done);
  endfunction

  task automatic drive(input int d, input logic [3:0] c, input logic v);
    if (d == 0) begin
      if0.cmd = c; if0.cmd_valid = v;
    end else begin
      if1.cmd = c; if1.cmd_valid = v;
    end
  endtask

  // Hold the command valid for n consecutive accept edges.
  task automatic issue(input int d, input logic [3:0] c, input int n);
    @(negedge clk);
    drive(d, c, 1'b1);
    repeat (n) @(negedge clk);
    drive(d, c, 1'b0);
  endtask

  task automatic wait_idle(input int d, input string name);
    int n = 0;
    while (busy_of(d) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy_of(d), 0);
  endtask

  task automatic writeback(input int d, input string name);
    wr_t e;
    int  n = 0;
    for (int i = 0; i < 64; i++) begin
      e.a = i;
      e.d = (d == 0) ? m0[i] : m1[i];
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    if (d == 0) pend0++; else pend1++;
    issue(d, WRTBK, 1);
    while (done_of(d) == 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_done"}, done_of(d), 1);
    chk({name, "_busy_in_done"}, busy_of(d), 1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, done_of(d), 0);
    chk({name, "_busy_after"}, busy_of(d), 0);
    chk({name, "_drained"}, (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time %0t exceeded, required finish earlier", $time);
    $fatal(1);
  end

  initial begin
    int n;
    tests = 0; fails = 0; pend0 = 0; pend1 = 0;
    for (int i = 0; i < 64; i++) begin
      rom0[i] = 8'(i);
      rom1[i] = 8'(i + 100);
      m0[i]   = i;
      m1[i]   = i + 100;
    end
    drive(0, AVG, 1'b1);   // held through load: must be ignored
    drive(1, 4'd0, 1'b0);

    // Reset values of the 8x8 instance
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(if0.busy), 1);
    chk("rst_done", int'(if0.done), 0);
    chk("rst_irom_en", int'(if0.IROM_EN), 1);
    chk("rst_irom_a", int'(if0.IROM_A), 0);
    chk("rst_irb_rw", int'(if0.IRB_RW), 1);
    chk("rst_irb_a", int'(if0.IRB_A), 0);
    chk("rst_irb_d", int'(if0.IRB_D), 0);

    // Load sequence: addresses 0..63 with enable low, busy falls on edge 65
    rst0 = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("load_irom_a", int'(if0.IROM_A), k);
      chk("load_irom_en", int'(if0.IROM_EN), 0);
      if (k == 60) drive(0, AVG, 1'b0);
    end
    @(negedge clk);
    chk("load_busy_fall", int'(if0.busy), 0);
    chk("load_irom_en_off", int'(if0.IROM_EN), 1);
    writeback(0, "wb_init");

    // AVG at (4,4): 27+28+35+36 = 126, /4 = 31
    issue(0, AVG, 1);
    m0[27] = 31; m0[28] = 31; m0[35] = 31; m0[36] = 31;
    writeback(0, "wb_avg");

    // Saturate at (1,1), mirror; NOPs; saturate at (7,7), MIN of 54,55,62,63
    issue(0, UP, 5);
    issue(0, LF, 5);
    issue(0, MRR_X, 1);
    m0[0] = 8; m0[1] = 9; m0[8] = 0; m0[9] = 1;
    issue(0, 4'd13, 1);
    issue(0, 4'd15, 2);
    issue(0, DN, 9);
    issue(0, RT, 9);
    issue(0, MIN, 1);
    m0[54] = 54; m0[55] = 54; m0[62] = 54; m0[63] = 54;
    writeback(0, "wb_sat");

    // RELOAD restores frame and op (4,4)
    issue(0, RELOAD, 1);
    chk("reload_busy", int'(if0.busy), 1);
    wait_idle(0, "reload_idle");
    for (int i = 0; i < 64; i++) m0[i] = i;
    issue(0, ROT_CW, 1);
    m0[27] = 35; m0[28] = 27; m0[35] = 36; m0[36] = 28;
    writeback(0, "wb_rotcw");
    issue(0, ROT_CCW, 1);
    issue(0, MRR_Y, 1);
    m0[27] = 28; m0[28] = 27; m0[35] = 36; m0[36] = 35;
    writeback(0, "wb_ccw_mrry");
    issue(0, MAX, 1);
    m0[27] = 36; m0[28] = 36; m0[35] = 36; m0[36] = 36;
    writeback(0, "wb_max");

    // Reset while IRB_A=20 is on the bus: writes 0..20 only, then reload
    for (int i = 0; i <= 20; i++) begin
      wr_t e;
      e.a = i; e.d = m0[i];
      q0.push_back(e);
    end
    issue(0, WRTBK, 1);
    n = 0;
    while (!(if0.IRB_RW == 1'b0 && if0.IRB_A == 6'd20) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midwr_reach_i20", int'(if0.IRB_A), 20);
    rst0 = 1'b0;
    @(negedge clk);
    chk("midwr_rst_irb_rw", int'(if0.IRB_RW), 1);
    chk("midwr_rst_busy", int'(if0.busy), 1);
    chk("midwr_rst_irb_a", int'(if0.IRB_A), 0);
    chk("midwr_rst_done", int'(if0.done), 0);
    chk("midwr_drained", q0.size(), 0);
    rst0 = 1'b1;
    @(negedge clk);
    chk("midwr_reload_a0", int'(if0.IROM_A), 0);
    chk("midwr_reload_en", int'(if0.IROM_EN), 0);
    wait_idle(0, "midwr_idle");
    for (int i = 0; i < 64; i++) m0[i] = i;
    writeback(0, "wb_after_reset");

    // 16x4 instance: op starts (8,2); MIN of 123,124,139,140
    rst1 = 1'b1;
    wait_idle(1, "i1_load_idle");
    issue(1, MIN, 1);
    m1[23] = 123; m1[24] = 123; m1[39] = 123; m1[40] = 123;
    // DN x3 -> opY 3, RT x10 -> opX 15; MAX of 146,147,162,163
    issue(1, DN, 3);
    issue(1, RT, 10);
    issue(1, MAX, 1);
    m1[46] = 163; m1[47] = 163; m1[62] = 163; m1[63] = 163;
    writeback(1, "wb1_first");

    // Second frame: ROM now 200-i; AVG at (8,2): 177+176+161+160 = 674 -> 168
    for (int i = 0; i < 64; i++) begin
      rom1[i] = 8'(200 - i);
      m1[i]   = 200 - i;
    end
    issue(1, RELOAD, 1);
    wait_idle(1, "i1_reload_idle");
    issue(1, AVG, 1);
    m1[23] = 168; m1[24] = 168; m1[39] = 168; m1[40] = 168;
    writeback(1, "wb1_reload");

    repeat (3) @(negedge clk);
    chk("end_q0_empty", q0.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    chk("end_pend0", pend0, 0);
    chk("end_pend1", pend1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
